dcache_responder: RTL and testbench



---
 rtl/dcache_responder_if.sv | 32 +++
 rtl/dcache_responder.sv | 118 +++++++++++
 tb/tb_dcache_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_responder_if.sv
// CPU data-memory bus and physical-memory line port seen by dcache_responder.
interface dcache_responder_if;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_wdata;
   logic         mem_stall;
   logic         mem_resp;
   logic         mem_ready;
   logic [31:0]  mem_rdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   modport slave (
      input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata, mem_stall,
      input  pmem_rdata, pmem_resp,
      output mem_resp, mem_ready, mem_rdata,
      output pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata, mem_stall,
      output pmem_rdata, pmem_resp,
      input  mem_resp, mem_ready, mem_rdata,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache, 32-byte lines, 256-bit pmem port.
//   state     | meaning
//   IDLE      | compare tag; hits and idle cycles complete immediately
//   WRITEBACK | dirty victim line being written to pmem
//   ALLOCATE  | requested line being fetched from pmem
module dcache_responder #(
   parameter int S_INDEX = 3
) (
   input  logic              clk,
   input  logic              rst,
   dcache_responder_if.slave bus
);
   localparam int SETS  = 1 << S_INDEX;
   localparam int TAG_W = 27 - S_INDEX;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t state, next_state;

   logic [SETS-1:0]  valid;
   logic [SETS-1:0]  dirty;
   logic [TAG_W-1:0] tag_array  [SETS];
   logic [255:0]     data_array [SETS];

   logic [2:0]         word_sel;
   logic [S_INDEX-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic               req, hit, do_load;
   logic [31:0]        cur_word, merged_word;
   logic               unused_addr_bits;

   assign word_sel = bus.mem_address[4:2];
   assign index    = bus.mem_address[4+S_INDEX:5];
   assign tag      = bus.mem_address[31:5+S_INDEX];
   assign unused_addr_bits = ^bus.mem_address[1:0];

   assign req      = bus.mem_read | bus.mem_write;
   assign hit      = valid[index] && (tag_array[index] == tag);
   assign do_load  = (state == IDLE) && hit && bus.mem_read && !bus.mem_write;
   assign cur_word = data_array[index][{word_sel, 5'b0} +: 32];

   always_comb begin
      merged_word = cur_word;
      for (int b = 0; b < 4; b++) begin
         if (bus.mem_byte_enable[b]) merged_word[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (req && !hit) next_state = (valid[index] && dirty[index]) ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (bus.pmem_resp) next_state = ALLOCATE;
         ALLOCATE:  if (bus.pmem_resp) next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_resp     = 1'b0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = {tag, index, 5'b0};
      bus.pmem_wdata   = data_array[index];
      case (state)
         IDLE:      bus.mem_resp = !rst && (!req || hit);
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_array[index], index, 5'b0};
         end
         ALLOCATE:  bus.pmem_read = 1'b1;
         default:   bus.mem_resp = 1'b0;
      endcase
   end

   // Valid/dirty are the only array state that must be cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else begin
         case (state)
            IDLE:      if (hit && bus.mem_write && (bus.mem_byte_enable != 4'b0)) dirty[index] <= 1'b1;
            WRITEBACK: if (bus.pmem_resp) dirty[index] <= 1'b0;
            ALLOCATE:  if (bus.pmem_resp) begin
               valid[index] <= 1'b1;
               dirty[index] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == ALLOCATE && bus.pmem_resp) begin
         data_array[index] <= bus.pmem_rdata;
         tag_array[index]  <= tag;
      end else if (state == IDLE && hit && bus.mem_write) begin
         data_array[index][{word_sel, 5'b0} +: 32] <= merged_word;
      end
   end

   // A frozen WB stage keeps the previous load result visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mem_ready <= 1'b0;
         bus.mem_rdata <= 32'h0;
      end else if (!bus.mem_stall) begin
         bus.mem_ready <= do_load;
         if (do_load) bus.mem_rdata <= cur_word;
      end
   end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed scoreboard bench for dcache_responder with a 3-cycle pmem model.
module tb_dcache_responder;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   pm_cnt;

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] data;
   } pm_op_t;

   logic [31:0]  exp_q [$];
   pm_op_t       pm_log [$];
   logic [255:0] pmem_mem [logic [31:0]];
   logic [31:0]  arch [logic [31:0]];

   dcache_responder_if bus ();

   dcache_responder #(.S_INDEX(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [255:0] init_line(input logic [31:0] a);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word({a[31:5], 5'b0} + 32'(i*4));
      return l;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      if (arch.exists(a)) return arch[a];
      return init_word(a);
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // pmem model: completes any transfer on its third active cycle
   initial begin
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      pm_cnt = 0;
      forever begin
         @(negedge clk);
         if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
            pm_cnt = 0;
         end
         if (!rst && (bus.pmem_read || bus.pmem_write)) begin
            pm_cnt++;
            if (pm_cnt == 3) begin
               pm_op_t op;
               op.wr   = bus.pmem_write;
               op.addr = bus.pmem_address;
               op.data = bus.pmem_wdata;
               if (bus.pmem_write) begin
                  pmem_mem[bus.pmem_address] = bus.pmem_wdata;
               end else begin
                  bus.pmem_rdata = pmem_mem.exists(bus.pmem_address) ?
                                   pmem_mem[bus.pmem_address] : init_line(bus.pmem_address);
               end
               pm_log.push_back(op);
               bus.pmem_resp = 1'b1;
            end
         end else begin
            pm_cnt = 0;
         end
      end
   end

   task automatic set_idle();
      bus.mem_read        = 1'b0;
      bus.mem_write       = 1'b0;
      bus.mem_address     = 32'h0;
      bus.mem_byte_enable = 4'h0;
      bus.mem_wdata       = 32'h0;
   endtask

   // Entered just after a negedge; returns just after the negedge following the accept edge.
   task automatic access(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input int exp_wait);
      int  waited;
      bit  done;
      logic [31:0] w;
      bus.mem_read        = rd;
      bus.mem_write       = wr;
      bus.mem_address     = addr;
      bus.mem_byte_enable = be;
      bus.mem_wdata       = wd;
      waited = 0;
      done   = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         #1;
         if (bus.mem_resp) done = 1'b1;
         else begin
            waited++;
            @(negedge clk);
         end
      end
      if (!done) begin
         chk({tag, "_resp_timeout"}, bus.mem_resp, 1'b1);
         set_idle();
         return;
      end
      chk({tag, "_wait"}, waited, exp_wait);
      if (wr) begin
         w = exp_word(addr);
         for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
         arch[addr] = w;
      end else if (rd) begin
         exp_q.push_back(exp_word(addr));
      end
      @(negedge clk);
      set_idle();
      #1;
      chk({tag, "_ready"}, bus.mem_ready, rd && !wr);
      if (bus.mem_ready) begin
         if (exp_q.size() == 0) chk({tag, "_sb_empty"}, bus.mem_ready, 1'b0);
         else chk({tag, "_rdata"}, bus.mem_rdata, exp_q.pop_front());
      end
   endtask

   task automatic log_expect(input string tag, input bit wr, input logic [31:0] addr);
      pm_op_t op;
      if (pm_log.size() == 0) begin
         chk({tag, "_pmem_missing"}, 32'(pm_log.size()), 32'd1);
         return;
      end
      op = pm_log.pop_front();
      chk({tag, "_pmem_op"}, {op.wr, op.addr}, {wr, addr});
   endtask

   initial begin
      logic [255:0] l40;
      logic [31:0]  held;
      pm_op_t       op;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.mem_stall = 1'b0;
      set_idle();
      l40 = init_line(32'h40);
      l40[32 +: 32] = 32'hDEAD_BEEF;
      pmem_mem[32'h40] = l40;
      arch[32'h44]     = 32'hDEAD_BEEF;

      @(negedge clk);
      #1;
      chk("rst_resp", bus.mem_resp, 1'b0);
      chk("rst_ready", bus.mem_ready, 1'b0);
      chk("rst_rdata", bus.mem_rdata, 32'h0);
      chk("rst_pmem", {bus.pmem_read, bus.pmem_write}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_resp", bus.mem_resp, 1'b1);
      chk("idle_pmem", {bus.pmem_read, bus.pmem_write, bus.mem_ready}, 3'b000);
      @(negedge clk);

      access("cold_load", 1, 0, 32'h44, 4'h0, 32'h0, 4);
      log_expect("cold_load", 1'b0, 32'h40);
      access("store_hit", 0, 1, 32'h44, 4'b0010, 32'h0000_5500, 0);
      chk("store_no_pmem", 32'(pm_log.size()), 32'd0);
      access("load_merged", 1, 0, 32'h44, 4'h0, 32'h0, 0);

      access("alias_load", 1, 0, 32'h144, 4'h0, 32'h0, 7);
      if (pm_log.size() != 0) begin
         op = pm_log[0];
         chk("wb_word1", op.data[32 +: 32], 32'hDEAD_55EF);
      end
      log_expect("alias_wb", 1'b1, 32'h40);
      log_expect("alias_fill", 1'b0, 32'h140);

      access("stall_load", 1, 0, 32'h144, 4'h0, 32'h0, 0);
      held = exp_word(32'h144);
      bus.mem_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk("stall_ready", bus.mem_ready, 1'b1);
         chk("stall_rdata", bus.mem_rdata, held);
      end
      bus.mem_stall = 1'b0;
      @(negedge clk);
      #1;
      chk("unstall_ready", bus.mem_ready, 1'b0);
      chk("unstall_rdata", bus.mem_rdata, held);
      @(negedge clk);

      access("rdwr_store", 1, 1, 32'h148, 4'hF, 32'h1234_5678, 0);
      access("rdwr_load", 1, 0, 32'h148, 4'h0, 32'h0, 0);

      access("be0_store_miss", 0, 1, 32'h88, 4'h0, 32'hFFFF_FFFF, 4);
      log_expect("be0_fill", 1'b0, 32'h80);
      access("be0_alias_load", 1, 0, 32'h188, 4'h0, 32'h0, 4);
      log_expect("be0_no_wb", 1'b0, 32'h180);

      bus.mem_read    = 1'b1;
      bus.mem_address = 32'h200;
      @(negedge clk);
      #1;
      chk("alloc_pmem_read", bus.pmem_read, 1'b1);
      chk("alloc_pmem_addr", bus.pmem_address, 32'h200);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_pmem", {bus.pmem_read, bus.pmem_write}, 2'b00);
      chk("async_rst_resp", bus.mem_resp, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_log", 32'(pm_log.size()), 32'd0);
      access("post_rst_load", 1, 0, 32'h200, 4'h0, 32'h0, 4);
      log_expect("post_rst_fill", 1'b0, 32'h200);
      access("post_rst_wb_data", 1, 0, 32'h44, 4'h0, 32'h0, 4);
      log_expect("post_rst_fill40", 1'b0, 32'h40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end
endmodule
